// File: rtl/reg_pkg.sv
// Shared types and defaults for the register read ports.
// Exports default widths and the response record held by resp_skid_fifo.
package reg_pkg;

    localparam int DATA_WIDTH = 8;
    localparam int ADDR_WIDTH = 4;
    localparam int NUM_REGS   = 8;

    // One read response: snapshotted data plus out-of-range flag.
    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic                  err;
    } rd_resp_t;

    // Empty response used whenever the buffer has nothing to present.
    localparam rd_resp_t RESP_NONE = '{data: '0, err: 1'b0};

    // Next occupancy of a small FIFO given the qualified push/pop strobes.
    function automatic logic [1:0] next_count(
        input logic [1:0] count,
        input logic       push,
        input logic       pop
    );
        logic [1:0] res;
        res = count;
        unique case ({push, pop})
            2'b10:   res = count + 2'd1;
            2'b01:   res = count - 2'd1;
            default: res = count;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/resp_skid_fifo.sv
// Two-entry FIFO of rd_resp_t, shared by the register read ports.
// Ports: clk_i, rst_i (sync, active high), push_i/push_data_i, pop_i,
//        head_o (zero when empty), count_o (0..2), empty_o.
module resp_skid_fifo
    import reg_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       push_i,
    input  rd_resp_t   push_data_i,
    input  logic       pop_i,
    output rd_resp_t   head_o,
    output logic [1:0] count_o,
    output logic       empty_o
);

    rd_resp_t   mem_q [2];
    logic       wr_ptr_q;
    logic       rd_ptr_q;
    logic [1:0] count_q;
    logic [1:0] count_d;
    logic       full;
    logic       push_ok;
    logic       pop_ok;

    assign full    = (count_q == 2'd2);
    assign empty_o = (count_q == 2'd0);
    assign count_o = count_q;

    // Strobes are qualified here so a misbehaving caller can never
    // overrun or underrun the pointers.
    assign push_ok = push_i & ~full;
    assign pop_ok  = pop_i & ~empty_o;

    always_comb begin
        count_d = next_count(count_q, push_ok, pop_ok);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mem_q[0] <= RESP_NONE;
            mem_q[1] <= RESP_NONE;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            count_q <= count_d;
            if (push_ok) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop_ok) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
        end
    end

    // Head is forced to zero when empty so consumers see clean data.
    always_comb begin
        head_o = RESP_NONE;
        if (!empty_o) begin
            head_o = mem_q[rd_ptr_q];
        end
    end

endmodule

// File: rtl/register_read_port.sv
// Register storage with a buffered valid/ready read port and write bypass.
// Ports: clk, rst, write_enable/write_addr/data_in (write side),
//        rd_req_valid/rd_req_ready/rd_addr (request),
//        rd_resp_valid/rd_resp_ready/rd_data/rd_err (response).
module register_read_port #(
    parameter int DATA_WIDTH = reg_pkg::DATA_WIDTH,
    parameter int NUM_REGS   = reg_pkg::NUM_REGS,
    parameter int ADDR_WIDTH = reg_pkg::ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  write_enable,
    input  logic [ADDR_WIDTH-1:0] write_addr,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  rd_req_valid,
    output logic                  rd_req_ready,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rd_resp_valid,
    input  logic                  rd_resp_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_err
);

    import reg_pkg::rd_resp_t;

    // Register count in address width + 1 so the range check never wraps.
    localparam logic [ADDR_WIDTH:0] NUM_REGS_W = NUM_REGS[ADDR_WIDTH:0];

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];

    logic                  wr_in_range;
    logic                  rd_in_range;
    logic                  bypass_hit;
    logic [DATA_WIDTH-1:0] rd_reg_data;
    logic                  req_fire;
    logic                  resp_fire;
    rd_resp_t              resp_push;
    rd_resp_t              resp_head;
    logic [1:0]            resp_count;
    logic                  resp_empty;

    assign wr_in_range = ({1'b0, write_addr} < NUM_REGS_W);
    assign rd_in_range = ({1'b0, rd_addr} < NUM_REGS_W);

    // Write decode: an out-of-range address matches no register.
    always_comb begin
        regs_d = regs_q;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (write_enable && (write_addr == ADDR_WIDTH'(i))) begin
                regs_d[i] = data_in;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // Read mux over the stored registers.
    always_comb begin
        rd_reg_data = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rd_addr == ADDR_WIDTH'(i)) begin
                rd_reg_data = regs_q[i];
            end
        end
    end

    // A write landing on the same edge as the accept wins over the array.
    assign bypass_hit = write_enable & wr_in_range & (write_addr == rd_addr);

    always_comb begin
        resp_push = '0;
        if (!rd_in_range) begin
            resp_push.data = '0;
            resp_push.err  = 1'b1;
        end else if (bypass_hit) begin
            resp_push.data = data_in;
        end else begin
            resp_push.data = rd_reg_data;
        end
    end

    // Ready depends only on buffer occupancy, never on rd_resp_ready.
    assign rd_req_ready  = (resp_count < 2'd2);
    assign rd_resp_valid = ~resp_empty;

    // A request seen during reset is dropped along with the buffer.
    assign req_fire  = rd_req_valid & rd_req_ready & ~rst;
    assign resp_fire = rd_resp_valid & rd_resp_ready;

    resp_skid_fifo u_resp_fifo (
        .clk_i       (clk),
        .rst_i       (rst),
        .push_i      (req_fire),
        .push_data_i (resp_push),
        .pop_i       (resp_fire),
        .head_o      (resp_head),
        .count_o     (resp_count),
        .empty_o     (resp_empty)
    );

    assign rd_data = resp_head.data;
    assign rd_err  = resp_head.err;

endmodule

// File: tb/tb_register_read_port.sv
// Bench for register_read_port: directed scenarios plus random traffic.
// Outputs are compared against a queue/array reference model.
module tb_register_read_port;

    logic       clk = 1'b0;
    logic       rst;
    logic       write_enable;
    logic [3:0] write_addr;
    logic [7:0] data_in;
    logic       rd_req_valid;
    logic       rd_req_ready;
    logic [3:0] rd_addr;
    logic       rd_resp_valid;
    logic       rd_resp_ready;
    logic [7:0] rd_data;
    logic       rd_err;

    int checks = 0;
    int errors = 0;

    logic [7:0] mregs [8];
    logic [8:0] mq [$];
    bit         model_ok = 0;
    int         resp_seen;

    always #5 clk = ~clk;

    register_read_port #(
        .DATA_WIDTH (8),
        .NUM_REGS   (8),
        .ADDR_WIDTH (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .write_enable  (write_enable),
        .write_addr    (write_addr),
        .data_in       (data_in),
        .rd_req_valid  (rd_req_valid),
        .rd_req_ready  (rd_req_ready),
        .rd_addr       (rd_addr),
        .rd_resp_valid (rd_resp_valid),
        .rd_resp_ready (rd_resp_ready),
        .rd_data       (rd_data),
        .rd_err        (rd_err)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic r, input logic we, input int wa,
                         input logic [7:0] d, input logic rv, input int ra,
                         input logic rr);
        rst           = r;
        write_enable  = we;
        write_addr    = 4'(wa);
        data_in       = d;
        rd_req_valid  = rv;
        rd_addr       = 4'(ra);
        rd_resp_ready = rr;
    endtask

    // Compare current outputs with the model, advance the model, clock.
    task automatic cycle();
        logic [8:0] head;
        logic [8:0] resp;
        bit         fire_req;
        bit         fire_resp;
        if (model_ok) begin
            head = (mq.size() != 0) ? mq[0] : 9'h0;
            chk("req_ready", 32'(rd_req_ready), 32'(mq.size() < 2));
            chk("resp_valid", 32'(rd_resp_valid), 32'(mq.size() != 0));
            chk("rd_data", 32'(rd_data), 32'(head[8:1]));
            chk("rd_err", 32'(rd_err), 32'(head[0]));
        end
        if (rd_resp_valid && rd_resp_ready) resp_seen++;
        if (rst) begin
            for (int i = 0; i < 8; i++) mregs[i] = 8'h0;
            mq.delete();
            model_ok = 1;
        end else begin
            resp = 9'h0;
            fire_resp = rd_resp_ready && (mq.size() != 0);
            fire_req  = rd_req_valid && (mq.size() < 2);
            if (fire_req) begin
                if (rd_addr >= 4'd8)
                    resp = {8'h00, 1'b1};
                else if (write_enable && write_addr == rd_addr)
                    resp = {data_in, 1'b0};
                else
                    resp = {mregs[rd_addr[2:0]], 1'b0};
            end
            if (fire_resp) void'(mq.pop_front());
            if (fire_req) mq.push_back(resp);
            if (write_enable && write_addr < 4'd8)
                mregs[write_addr[2:0]] = data_in;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset
        drive(1, 0, 0, 8'h00, 0, 0, 1);
        cycle();
        cycle();
        drive(0, 0, 0, 8'h00, 0, 0, 1);
        chk("rst_valid", 32'(rd_resp_valid), 32'd0);
        chk("rst_ready", 32'(rd_req_ready), 32'd1);
        chk("rst_data", 32'(rd_data), 32'h0);

        // Write then read reg 3
        drive(0, 1, 3, 8'h01, 0, 0, 1);
        cycle();
        drive(0, 0, 0, 8'h00, 1, 3, 1);
        cycle();
        chk("t1_valid", 32'(rd_resp_valid), 32'd1);
        chk("t1_data", 32'(rd_data), 32'h01);
        chk("t1_err", 32'(rd_err), 32'd0);
        drive(0, 0, 0, 8'h00, 0, 0, 1);
        cycle();

        // Bypass, then snapshot under stall
        drive(0, 1, 2, 8'hA5, 1, 2, 0);
        cycle();
        chk("byp_data", 32'(rd_data), 32'hA5);
        drive(0, 1, 2, 8'h5A, 0, 0, 0);
        cycle();
        chk("snap_data", 32'(rd_data), 32'hA5);
        chk("snap_valid", 32'(rd_resp_valid), 32'd1);
        drive(0, 0, 0, 8'h00, 0, 0, 1);
        cycle();

        // Back-pressure with distinct register contents
        drive(0, 1, 0, 8'h10, 0, 0, 1);
        cycle();
        drive(0, 1, 1, 8'h11, 0, 0, 1);
        cycle();
        drive(0, 0, 0, 8'h00, 1, 0, 0);
        cycle();
        drive(0, 0, 0, 8'h00, 1, 1, 0);
        cycle();
        drive(0, 0, 0, 8'h00, 1, 2, 0);
        cycle();
        chk("bp_ready", 32'(rd_req_ready), 32'd0);
        chk("bp_head0", 32'(rd_data), 32'h10);
        drive(0, 0, 0, 8'h00, 1, 2, 1);
        cycle();
        chk("bp_head1", 32'(rd_data), 32'h11);
        chk("bp_ready1", 32'(rd_req_ready), 32'd1);
        cycle();
        chk("bp_head2", 32'(rd_data), 32'h5A);
        drive(0, 0, 0, 8'h00, 0, 0, 1);
        cycle();

        // Out-of-range read and write
        drive(0, 0, 0, 8'h00, 1, 9, 0);
        cycle();
        chk("oor_data", 32'(rd_data), 32'h00);
        chk("oor_err", 32'(rd_err), 32'd1);
        drive(0, 1, 9, 8'hFF, 0, 0, 1);
        cycle();
        for (int i = 0; i < 8; i++) begin
            drive(0, 0, 0, 8'h00, 1, i, 1);
            cycle();
        end
        drive(0, 0, 0, 8'h00, 0, 0, 1);
        cycle();

        // Stream of 16 reads
        resp_seen = 0;
        for (int i = 0; i < 17; i++) begin
            drive(0, 0, 0, 8'h00, i < 16, i % 8, 1);
            cycle();
            if (i < 16) begin
                chk("str_valid", 32'(rd_resp_valid), 32'd1);
                chk("str_ready", 32'(rd_req_ready), 32'd1);
            end
        end
        chk("str_count", 32'(resp_seen), 32'd16);

        // Fill then reset
        drive(0, 0, 0, 8'h00, 1, 3, 0);
        cycle();
        cycle();
        drive(1, 1, 4, 8'h77, 1, 4, 0);
        cycle();
        chk("mrst_valid", 32'(rd_resp_valid), 32'd0);
        chk("mrst_ready", 32'(rd_req_ready), 32'd1);
        for (int i = 0; i < 8; i++) begin
            drive(0, 0, 0, 8'h00, 1, i, 1);
            cycle();
            chk("mrst_reg", 32'(rd_data), 32'h0);
        end
        drive(0, 0, 0, 8'h00, 0, 0, 1);
        cycle();

        // Random traffic
        for (int i = 0; i < 500; i++) begin
            drive(($urandom % 60) == 0,
                  1'($urandom % 2), int'($urandom % 10),
                  8'($urandom),
                  1'($urandom % 2), int'($urandom % 10),
                  ($urandom % 10) < 7);
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/register_read_port.md
# register_read_port

Read side of the register storage: holds `NUM_REGS` data registers written through the same single-port write interface as `simple_register`, and serves read requests over a valid/ready request/response handshake with a 2-entry response buffer. It sits between the register storage and any consumer that can stall, such as the ALU operand fetch or the debug readback path. Reads see same-cycle writes through a write-through bypass.

## Interface
- `DATA_WIDTH`, 8, width of each register and of read data
- `NUM_REGS`, 8, number of registers; addresses `0..NUM_REGS-1` are valid
- `ADDR_WIDTH`, 4, width of `write_addr`/`rd_addr`; must satisfy `2**ADDR_WIDTH >= NUM_REGS`
- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `write_enable`  in  1  write strobe; register `write_addr` loads `data_in` at the edge
- `write_addr`  in  ADDR_WIDTH  write target
- `data_in`  in  DATA_WIDTH  write data
- `rd_req_valid`  in  1  read request present
- `rd_req_ready`  out  1  block can accept a request
- `rd_addr`  in  ADDR_WIDTH  read address, qualified by `rd_req_valid`
- `rd_resp_valid`  out  1  response present
- `rd_resp_ready`  in  1  consumer accepts response
- `rd_data`  out  DATA_WIDTH  read data (head of response buffer)
- `rd_err`  out  1  head response was an out-of-range address

## Operation
- Reset: all registers 0; buffer count 0; `rd_resp_valid`=0, `rd_data`=0, `rd_err`=0, `rd_req_ready`=1 from the first cycle after reset.
- Write: `write_enable`=1 with `write_addr < NUM_REGS` loads `data_in` at the edge. Out-of-range writes are dropped silently. `write_enable` is ignored while `rst`=1.
- Request accept: `req_fire = rd_req_valid & rd_req_ready`. `rd_req_ready = (count < 2)`; it is a registered-state function only, with no combinational path from `rd_resp_ready`.
- Response formation at a `req_fire` edge:
  - Data is `regs[rd_addr]`.
  - If `write_enable` targets the same in-range address in that cycle, data is `data_in` (bypass).
  - If `rd_addr >= NUM_REGS`: data is 0 and `err`=1.
  - The `{data, err}` pair is pushed into the buffer.
- Response pop: `resp_fire = rd_resp_valid & rd_resp_ready` removes the head entry. `rd_resp_valid = (count != 0)`.
- Buffer:
  - 2-entry FIFO; count range 0..2.
  - Push and pop in the same cycle leaves count unchanged. Order is strictly FIFO.
  - When count is 0, `rd_data`/`rd_err` read as 0.
- A buffered response does not track later writes: data is snapshotted at accept time.
- `rst` asserted mid-operation discards all buffered responses at that edge; a request presented in the same cycle is not accepted.

## Timing
- Read latency 1: a request accepted at edge N gives `rd_resp_valid`=1 with its data in the cycle after edge N.
- Throughput 1 request/cycle whenever `rd_resp_ready` is held high. The count stays at 1 in steady state.
- Back-pressure: with `rd_resp_ready`=0, at most 2 requests are accepted, then `rd_req_ready`=0. It returns to 1 the cycle after the first pop.
- `rd_data`, `rd_err` and `rd_resp_valid` remain stable while `rd_resp_valid & !rd_resp_ready`.
- A write at edge N is visible to:
  - requests accepted at edge N, via the bypass;
  - all later requests.

## Structure
- Shared package `reg_pkg`:
  - `DATA_WIDTH`/`ADDR_WIDTH` defaults;
  - `typedef struct packed { logic [DATA_WIDTH-1:0] data; logic err; } rd_resp_t`.
- Sub-module `resp_skid_fifo`: 2-entry FIFO of `rd_resp_t` with push/pop/count, reused by other read ports.
- The top level holds the register array, write decode, bypass mux and out-of-range check.

## Test plan
- Reset, write 0x01 to reg 3, then read reg 3 with `rd_resp_ready`=1 → one cycle after accept, `rd_resp_valid`=1, `rd_data`=0x01, `rd_err`=0.
- Same cycle: write 0xA5 to reg 2 and accept a read of reg 2 → response 0xA5. Then write 0x5A to reg 2 while the response is stalled → stalled response stays 0xA5.
- Hold `rd_resp_ready`=0 and present reads of regs 0, 1, 2 back to back → only 2 accepted, `rd_req_ready`=0. Release → responses come out in order 0, 1, then reg 2 is accepted.
- Read address 9 with `NUM_REGS`=8 → `rd_data`=0x00, `rd_err`=1. A write to address 9 leaves all registers unchanged.
- Stream 16 reads with `rd_resp_ready`=1 → 16 responses in 16 consecutive cycles, with no `rd_req_ready` drop.
- Fill the buffer to 2, then pulse `rst` → next cycle `rd_resp_valid`=0, `rd_req_ready`=1, and all registers read 0.
